// File: rtl/add_sub_pipeline.sv
// rtl/add_sub_pipeline.sv - two-stage elastic add/subtract unit around a carry-bypass adder
// Operand stage conditions B/carry for subtract; result stage registers sum and CF/OF/ZF/NF.

module carry_bypass_adder #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  cin_i,
  output logic [DATA_WIDTH-1:0] s_o,
  output logic                  cout_o,
  output logic                  of_o
);
  localparam int NUM_BLOCKS = DATA_WIDTH / BLOCK_SIZE;

  logic blk_c;
  logic rc;
  logic prop;
  logic c_msb;

  // Each block ripples internally; a fully propagating block forwards its carry-in directly.
  always_comb begin
    blk_c = cin_i;
    s_o   = '0;
    c_msb = 1'b0;
    rc    = 1'b0;
    prop  = 1'b0;
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      rc   = blk_c;
      prop = 1'b1;
      for (int j = 0; j < BLOCK_SIZE; j++) begin
        if (k * BLOCK_SIZE + j == DATA_WIDTH - 1) c_msb = rc;
        s_o[k*BLOCK_SIZE+j] = a_i[k*BLOCK_SIZE+j] ^ b_i[k*BLOCK_SIZE+j] ^ rc;
        rc   = (a_i[k*BLOCK_SIZE+j] & b_i[k*BLOCK_SIZE+j]) |
               ((a_i[k*BLOCK_SIZE+j] ^ b_i[k*BLOCK_SIZE+j]) & rc);
        prop = prop & (a_i[k*BLOCK_SIZE+j] ^ b_i[k*BLOCK_SIZE+j]);
      end
      blk_c = prop ? blk_c : rc;
    end
    cout_o = blk_c;
    of_o   = c_msb ^ blk_c;
  end
endmodule

module add_sub_pipeline #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_a_i,
  input  logic [DATA_WIDTH-1:0] in_b_i,
  input  logic                  in_op_i,
  input  logic                  in_cin_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_s_o,
  output logic                  out_cf_o,
  output logic                  out_of_o,
  output logic                  out_zf_o,
  output logic                  out_nf_o
);
  logic [DATA_WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
  logic                  c1_q, c1_d, s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s_q, s_d;
  logic                  cf_q, cf_d, of_q, of_d, zf_q, zf_d, nf_q, nf_d;
  logic                  s2_valid_q, s2_valid_d;

  logic                  s2_free, s1_advance, accept;
  logic [DATA_WIDTH-1:0] sum;
  logic                  sum_cf, sum_of;

  assign s2_free    = !s2_valid_q || out_ready_i;
  assign s1_advance = s1_valid_q && s2_free;
  assign in_ready_o = !s1_valid_q || s2_free;
  assign accept     = in_valid_i && in_ready_o;

  carry_bypass_adder #(
    .DATA_WIDTH(DATA_WIDTH),
    .BLOCK_SIZE(BLOCK_SIZE)
  ) u_adder (
    .a_i   (a1_q),
    .b_i   (b1_q),
    .cin_i (c1_q),
    .s_o   (sum),
    .cout_o(sum_cf),
    .of_o  (sum_of)
  );

  // Subtract is A + ~B + ~borrow, so both B and the carry-in are inverted here.
  always_comb begin
    a1_d       = a1_q;
    b1_d       = b1_q;
    c1_d       = c1_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      a1_d       = in_a_i;
      b1_d       = in_op_i ? ~in_b_i : in_b_i;
      c1_d       = in_op_i ? ~in_cin_i : in_cin_i;
      s1_valid_d = 1'b1;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s_d        = s_q;
    cf_d       = cf_q;
    of_d       = of_q;
    zf_d       = zf_q;
    nf_d       = nf_q;
    s2_valid_d = s2_valid_q;
    if (s1_advance) begin
      s_d        = sum;
      cf_d       = sum_cf;
      of_d       = sum_of;
      zf_d       = (sum == '0);
      nf_d       = sum[DATA_WIDTH-1];
      s2_valid_d = 1'b1;
    end else if (out_ready_i) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a1_q       <= '0;
      b1_q       <= '0;
      c1_q       <= 1'b0;
      s1_valid_q <= 1'b0;
      s_q        <= '0;
      cf_q       <= 1'b0;
      of_q       <= 1'b0;
      zf_q       <= 1'b0;
      nf_q       <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      a1_q       <= a1_d;
      b1_q       <= b1_d;
      c1_q       <= c1_d;
      s1_valid_q <= s1_valid_d;
      s_q        <= s_d;
      cf_q       <= cf_d;
      of_q       <= of_d;
      zf_q       <= zf_d;
      nf_q       <= nf_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_s_o     = s_q;
  assign out_cf_o    = cf_q;
  assign out_of_o    = of_q;
  assign out_zf_o    = zf_q;
  assign out_nf_o    = nf_q;
endmodule

// File: doc/add_sub_pipeline.md
Name: add_sub_pipeline

Overview:
Two-stage elastic add/subtract unit that wraps the team's carry-bypass adder with registered operand and result stages and a valid/ready handshake on both sides. The operand stage builds the adder inputs: it conditions B (inverts it for subtract) and derives the carry-in. The result stage captures the sum and the CF/OF outputs, and adds zero and negative flags. The block sits between an upstream operand producer (issue logic or a testbench driver) and a downstream consumer (result writeback), so the adder can be used in clocked datapaths.

Parameters:
DATA_WIDTH, 16, operand/result width in bits; must be a multiple of BLOCK_SIZE.
BLOCK_SIZE, 4, bypass block size passed to the internal carry-bypass adder.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents an operation
in_ready  output  1  block can accept an operation this cycle
in_a  input  DATA_WIDTH  operand A
in_b  input  DATA_WIDTH  operand B
in_op  input  1  0 = add, 1 = subtract (A - B)
in_cin  input  1  add: carry-in; subtract: borrow-in
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_s  output  DATA_WIDTH  sum/difference
out_cf  output  1  adder carry-out (subtract: 1 = no borrow)
out_of  output  1  signed overflow
out_zf  output  1  out_s == 0
out_nf  output  1  out_s MSB

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: s1_valid = 0, s2_valid = 0, out_valid = 0, and out_s/out_cf/out_of/out_zf/out_nf = 0. in_ready is 1 one cycle after reset deassertion. Reset asserted mid-operation discards both stages immediately. No result from before reset ever appears.
- Stage 1 (operand register): on accept (in_valid && in_ready), the following registers are loaded:
  - a1 = in_a
  - b1 = in_op ? ~in_b : in_b
  - c1 = in_op ? ~in_cin : in_cin
  - s1_valid = 1
- Combinational: the carry-bypass adder is instantiated on a1, b1, c1. It produces S, CF and OF, where OF is carry into the MSB XOR carry out of the MSB.
- Stage 2 (result register): on s1 advance, the following registers are loaded:
  - out_s = S
  - out_cf = CF
  - out_of = OF
  - out_zf = (S == 0)
  - out_nf = S[DATA_WIDTH-1]
  - s2_valid = 1
- Handshake:
  - s2_free = !s2_valid || out_ready
  - s1_advance = s1_valid && s2_free
  - in_ready = !s1_valid || s2_free
- Handshake rules:
  - in_ready must not depend on in_valid.
  - out_valid = s2_valid.
  - Output data is held stable while out_valid && !out_ready.
  - s1_valid clears when s1 advances and no new accept occurs in the same cycle.
  - s2_valid clears on out_valid && out_ready when no s1 advance occurs in the same cycle.
- Simultaneous events: accept, s1 advance and output consume may all occur in one cycle. The pipeline then shifts fully with no bubble and no loss.
- Latency and throughput:
  - Latency is 2 cycles: an accept at edge n gives out_valid after edge n+1 when unstalled.
  - Throughput is one operation per cycle.
  - Capacity is 2 in-flight operations. With out_ready held low, exactly 2 are accepted and then in_ready = 0.
- Ordering: strict FIFO order and no duplication.
- Width rules:
  - All arithmetic is modulo 2^DATA_WIDTH; carry is reported only via CF.
  - Subtract with borrow-in b computes A + ~B + ~b = A - B - b.

Test Plan:
- Overflow, add, cin=0: 0x7FFF + 0x0001 -> out_s=0x8000, CF=0, OF=1, NF=1, ZF=0, out_valid exactly 2 cycles after accept.
- Equal operands, subtract, borrow=0: 0x0005 - 0x0005 -> out_s=0x0000, CF=1, ZF=1, OF=0, NF=0.
- Negative result, subtract: 0x0003 - 0x0005 -> out_s=0xFFFE, CF=0 (borrow), NF=1, OF=0. Signed overflow, subtract: 0x8000 - 0x0001 -> out_s=0x7FFF, OF=1.
- All-propagate path, add, cin=1: 0xFFFF + 0x0000 -> out_s=0x0000, CF=1, ZF=1. Repeat with 0x00FF + 0xFF00 -> same flags.
- Backpressure: out_ready=0; offer ops 1+1, 2+2, 3+3 back to back -> first two accepted, in_ready=0 on the third. out_s holds 0x0002 stable. Then raise out_ready -> results 0x0002, 0x0004, 0x0006 appear in order, one per cycle, none lost.
- Reset mid-operation: two ops in flight, assert rst_n=0 asynchronously between edges -> out_valid and all flags go 0 immediately. After release no stale result appears, and a new op 0x1234 + 0x0001 returns 0x1235.
